sample_frame_packer: RTL and testbench

- Read-side consumer of the acquisition FIFO, running in the FIFO read-clock domain.
- Pops 12-bit samples from the FIFO's read port and packs them into fixed-length byte frames: header, sequence number, sample bytes, checksum.
- Presents the frames on a valid/ready byte stream to the downstream serial transmitter (host link).
- Drives the FIFO read-enable: one pop per consumed sample, never on empty.

---
 rtl/sample_frame_packer_if.sv | 20 ++
 rtl/sample_frame_packer.sv | 98 +++++++++
 tb/tb_sample_frame_packer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_frame_packer_if.sv
// sample_frame_packer_if: FIFO read port and byte-stream link between the packer and its neighbours.
//   fifo_data_i  : FIFO head word (first-word fall-through), valid while fifo_empty_i=0
//   fifo_empty_i : FIFO empty flag
//   fifo_rd_o    : FIFO read-increment pulse, one per pop
//   tx_data_o    : byte to the serial transmitter
//   tx_valid_o   : tx_data_o valid
//   tx_ready_i   : transmitter accepts the byte this cycle
//   master modport is the packer side, slave modport is the FIFO/transmitter side.
interface sample_frame_packer_if #(
    parameter int DATA_SIZE = 12
);
    logic [DATA_SIZE-1:0] fifo_data_i;
    logic                 fifo_empty_i;
    logic                 fifo_rd_o;
    logic [7:0]           tx_data_o;
    logic                 tx_valid_o;
    logic                 tx_ready_i;
    modport master (input fifo_data_i, fifo_empty_i, tx_ready_i, output fifo_rd_o, tx_data_o, tx_valid_o);
    modport slave (output fifo_data_i, fifo_empty_i, tx_ready_i, input fifo_rd_o, tx_data_o, tx_valid_o);
endinterface

// File: rtl/sample_frame_packer.sv
// sample_frame_packer: pops samples from the read-domain FIFO and emits header/seq/sample/checksum byte frames.
//   clk_i    : read-domain clock
//   rst_i    : asynchronous active-low reset
//   enable_i : permits starting a new frame, sampled only in IDLE
//   busy_o   : high in any state other than IDLE
//   stall_o  : high while waiting in FETCH on an empty FIFO
//   bus      : FIFO read port and valid/ready byte stream (master side)
module sample_frame_packer #(
    parameter int          DATA_SIZE = 12,
    parameter int          FRAME_LEN = 64,
    parameter logic [7:0]  HEADER    = 8'hA5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    output logic busy_o,
    output logic stall_o,
    sample_frame_packer_if.master bus
);
    localparam int CW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    typedef enum logic [2:0] {IDLE, HDR, SEQ, FETCH, HI, LO, CSUM} state_t;
    state_t      state;
    logic [7:0]  sample_lo;
    logic [CW-1:0] cnt;
    logic [7:0]  csum;
    logic [7:0]  seq;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    assign bus.fifo_rd_o  = (state == FETCH) && !bus.fifo_empty_i;
    assign stall_o        = (state == FETCH) && bus.fifo_empty_i;
    assign bus.tx_data_o  = tx_data;
    assign bus.tx_valid_o = tx_valid;
    assign busy_o         = busy;
    // tx_data/tx_valid are loaded on the edge that enters each sending state, so they
    // stay stable until the transfer and never depend combinationally on tx_ready_i.
    // Only the low byte of a sample is kept: the high byte goes straight into tx_data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            sample_lo <= '0;
            cnt       <= '0;
            csum      <= '0;
            seq       <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable_i && !bus.fifo_empty_i) begin
                    state    <= HDR;
                    tx_data  <= HEADER;
                    tx_valid <= 1'b1;
                    busy     <= 1'b1;
                end
                HDR: if (bus.tx_ready_i) begin
                    state   <= SEQ;
                    tx_data <= seq;
                end
                SEQ: if (bus.tx_ready_i) begin
                    state    <= FETCH;
                    tx_valid <= 1'b0;
                end
                FETCH: if (!bus.fifo_empty_i) begin
                    state     <= HI;
                    sample_lo <= bus.fifo_data_i[7:0];
                    tx_data   <= 8'(bus.fifo_data_i >> 8);
                    tx_valid  <= 1'b1;
                end
                HI: if (bus.tx_ready_i) begin
                    state   <= LO;
                    csum    <= csum + tx_data;
                    tx_data <= sample_lo;
                end
                LO: if (bus.tx_ready_i) begin
                    csum <= csum + tx_data;
                    if (cnt == CW'(FRAME_LEN - 1)) begin
                        state   <= CSUM;
                        tx_data <= csum + tx_data;
                    end else begin
                        state    <= FETCH;
                        cnt      <= cnt + 1'b1;
                        tx_valid <= 1'b0;
                    end
                end
                CSUM: if (bus.tx_ready_i) begin
                    state    <= IDLE;
                    seq      <= seq + 8'd1;
                    cnt      <= '0;
                    csum     <= '0;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_frame_packer.sv
// tb_sample_frame_packer: directed bench for sample_frame_packer with a FIFO model and byte monitor.
module tb_sample_frame_packer;
    localparam int DS = 12;
    localparam int FL = 4;
    localparam int NB = 3 + 2 * FL;
    localparam int NF = 257;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic enable_i = 1'b0;
    logic busy_o;
    logic stall_o;

    always #5 clk_i = ~clk_i;

    sample_frame_packer_if #(.DATA_SIZE(DS)) bus ();

    sample_frame_packer #(.DATA_SIZE(DS), .FRAME_LEN(FL), .HEADER(8'hA5)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .enable_i(enable_i),
        .busy_o  (busy_o),
        .stall_o (stall_o),
        .bus     (bus.master)
    );

    int checks = 0;
    int errs = 0;
    int pops = 0;
    int rd_empty_err = 0;
    int hold_err = 0;
    int cyc = 0;
    bit pop_pend = 0;
    bit rand_ready = 0;
    bit held = 0;
    logic [7:0] held_data = '0;
    logic [DS-1:0] q [$];
    logic [7:0] got [$];
    int tt [$];
    logic [DS-1:0] bb [NF*FL];

    logic [7:0] h1 [NB] = '{8'hA5, 8'h00, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF, 8'h00, 8'h01, 8'hF9};
    logic [7:0] h4 [NB] = '{8'hA5, 8'h02, 8'h05, 8'hA5, 8'h00, 8'hF0, 8'h08, 8'h00, 8'h07, 8'hFF, 8'hA8};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic done();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    endtask

    function automatic void refresh();
        bus.fifo_empty_i = (q.size() == 0);
        bus.fifo_data_i  = (q.size() != 0) ? q[0] : '0;
    endfunction

    task automatic push(input logic [DS-1:0] w);
        q.push_back(w);
        refresh();
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Negedge monitor: records transfers, pops and handshake-stability violations.
    always @(negedge clk_i) begin
        cyc++;
        if (held && !(bus.tx_valid_o && bus.tx_data_o == held_data)) hold_err++;
        held = bus.tx_valid_o && !bus.tx_ready_i;
        held_data = bus.tx_data_o;
        pop_pend = bus.fifo_rd_o;
        if (bus.fifo_rd_o) pops++;
        if (bus.fifo_rd_o && bus.fifo_empty_i) rd_empty_err++;
        if (bus.tx_valid_o && bus.tx_ready_i) begin
            got.push_back(bus.tx_data_o);
            tt.push_back(cyc);
        end
    end

    // FIFO model: a pop seen before the edge advances the head just after it.
    always @(posedge clk_i) begin
        #1;
        if (pop_pend) begin
            if (q.size() != 0) void'(q.pop_front());
            refresh();
            pop_pend = 0;
        end
    end

    always @(posedge clk_i) begin
        #1;
        if (rand_ready) bus.tx_ready_i = 1'($urandom_range(0, 1));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic collect(input string tag, input int n);
        int k = 0;
        while (got.size() < n && k < 400) begin
            tick();
            k++;
        end
        if (got.size() < n) begin
            chk($sformatf("%s_timeout", tag), got.size(), n);
            done();
        end
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] e [NB], output int t0, output int t1);
        t0 = tt[0];
        t1 = tt[NB-1];
        for (int i = 0; i < NB; i++) chk($sformatf("%s_b%0d", tag, i), got[i], e[i]);
        repeat (NB) begin
            void'(got.pop_front());
            void'(tt.pop_front());
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] seq, input logic [DS-1:0] s [FL],
                               output int t0, output int t1);
        logic [7:0] e [NB];
        logic [7:0] cs;
        cs = '0;
        e[0] = 8'hA5;
        e[1] = seq;
        for (int i = 0; i < FL; i++) begin
            e[2+2*i] = 8'(s[i] >> 8);
            e[3+2*i] = s[i][7:0];
            cs = cs + e[2+2*i] + e[3+2*i];
        end
        e[NB-1] = cs;
        check_bytes(tag, e, t0, t1);
    endtask

    initial begin
        int t0, t1, pt1;
        logic [DS-1:0] s [FL];
        bus.tx_ready_i = 1'b0;
        refresh();
        tick();
        tick();
        chk("rst_valid", bus.tx_valid_o, 0);
        chk("rst_data", bus.tx_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_rd", bus.fifo_rd_o, 0);
        rst_i = 1'b1;
        enable_i = 1'b1;
        repeat (5) tick();
        chk("idle_busy", busy_o, 0);
        chk("idle_rd", bus.fifo_rd_o, 0);
        chk("idle_valid", bus.tx_valid_o, 0);

        bus.tx_ready_i = 1'b1;
        pops = 0;
        push(12'hABC); push(12'h123); push(12'hFFF); push(12'h001);
        @(negedge clk_i);
        chk("lat_before", bus.tx_valid_o, 0);
        @(negedge clk_i);
        chk("lat_after", bus.tx_valid_o, 1);
        collect("f1", NB);
        chk("f1_busy_end", busy_o, 0);
        check_bytes("f1", h1, t0, t1);
        chk("f1_pops", pops, FL);

        rand_ready = 1;
        push(12'hABC); push(12'h123); push(12'hFFF); push(12'h001);
        collect("f2", NB);
        s = '{12'hABC, 12'h123, 12'hFFF, 12'h001};
        check_frame("f2", 8'd1, s, t0, t1);
        rand_ready = 0;
        tick();
        bus.tx_ready_i = 1'b1;
        chk("hold_stable", hold_err, 0);

        push(12'h5A5); push(12'h0F0);
        collect("f3a", 6);
        repeat (3) tick();
        chk("stall_hi", stall_o, 1);
        chk("stall_valid", bus.tx_valid_o, 0);
        chk("stall_rd", bus.fifo_rd_o, 0);
        chk("stall_busy", busy_o, 1);
        push(12'h800); push(12'h7FF);
        @(negedge clk_i);
        chk("resume_rd", bus.fifo_rd_o, 1);
        chk("resume_stall", stall_o, 0);
        collect("f3", NB);
        check_bytes("f3", h4, t0, t1);

        push(12'h100); push(12'h200); push(12'h300); push(12'hF0F);
        collect("f4a", 1);
        enable_i = 1'b0;
        collect("f4", NB);
        s = '{12'h100, 12'h200, 12'h300, 12'hF0F};
        check_frame("f4", 8'd3, s, t0, t1);
        push(12'h111); push(12'h222); push(12'h333); push(12'h444);
        repeat (10) tick();
        chk("dis_busy", busy_o, 0);
        chk("dis_bytes", got.size(), 0);

        enable_i = 1'b1;
        collect("f5", 5);
        bus.tx_ready_i = 1'b0;
        #1;
        chk("pre_rst_valid", bus.tx_valid_o, 1);
        chk("pre_rst_lo", bus.tx_data_o, 8'h22);
        #1;
        rst_i = 1'b0;
        held = 0;
        #1;
        chk("mid_rst_valid", bus.tx_valid_o, 0);
        chk("mid_rst_data", bus.tx_data_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_stall", stall_o, 0);
        chk("mid_rst_rd", bus.fifo_rd_o, 0);
        got.delete();
        tt.delete();
        tick();
        rst_i = 1'b1;
        bus.tx_ready_i = 1'b1;
        push(12'h555); push(12'h666);
        collect("f6", NB);
        s = '{12'h333, 12'h444, 12'h555, 12'h666};
        check_frame("f6", 8'd0, s, t0, t1);

        rst_i = 1'b0;
        held = 0;
        tick();
        tick();
        q.delete();
        refresh();
        got.delete();
        tt.delete();
        pops = 0;
        rst_i = 1'b1;
        for (int i = 0; i < NF * FL; i++) begin
            bb[i] = DS'((i * 157 + 7) % 4096);
            push(bb[i]);
        end
        pt1 = 0;
        for (int f = 0; f < NF; f++) begin
            collect($sformatf("bb%0d", f), NB);
            for (int i = 0; i < FL; i++) s[i] = bb[f*FL+i];
            check_frame($sformatf("bb%0d", f), 8'(f), s, t0, t1);
            if (f > 0) chk($sformatf("gap%0d", f), t0 - pt1, 2);
            pt1 = t1;
        end
        chk("bb_pops", pops, NF * FL);
        chk("rd_on_empty", rd_empty_err, 0);
        done();
    end
endmodule
